// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Multi-cycle LoongArch core control FSM (IF/ID/EXE/MEM/WB) driving
//            all datapath strobes. Optional perf counters via MC_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
  parameter int IMEM_LAT = 1,
  parameter int DMEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_is_br,
  input  logic        inst_is_jl,
  input  logic        inst_is_ld,
  input  logic        inst_is_st,
  input  logic        inst_gr_we,
  input  logic        inst_legal,
  input  logic        br_taken,
  output logic [2:0]  state,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel_br,
  output logic        dmem_req,
  output logic        data_sram_we,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [2:0] IMEM_LAST = 3'(IMEM_LAT);
  localparam logic [2:0] DMEM_LAST = 3'(DMEM_LAT);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;

  always_ff @(posedge clk) begin
    state_q <= state_d;
    wait_q  <= wait_d;
  end

  always_comb begin
    state_d      = state_q;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel_br    = 1'b0;
    dmem_req     = 1'b0;
    data_sram_we = 1'b0;
    rf_we        = 1'b0;
    retire       = 1'b0;

    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (wait_q == IMEM_LAST) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        // Illegal opcodes retire as a nop, ahead of any class bit.
        if (!inst_legal) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (inst_is_br) begin
          pc_we     = 1'b1;
          pc_sel_br = br_taken;
          retire    = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (inst_is_jl)                    state_d = S_WB;
        else if (inst_is_ld || inst_is_st) state_d = S_MEM;
        else                               state_d = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (inst_is_ld) begin
          if (wait_q == DMEM_LAST) state_d = S_WB;
        end else begin
          data_sram_we = 1'b1;
          pc_we        = 1'b1;
          retire       = 1'b1;
          state_d      = S_IF;
        end
      end
      S_WB: begin
        rf_we     = inst_gr_we;
        pc_we     = 1'b1;
        pc_sel_br = inst_is_jl;
        retire    = 1'b1;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase

    if (reset) begin
      state_d      = S_IF;
      imem_req     = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel_br    = 1'b0;
      dmem_req     = 1'b0;
      data_sram_we = 1'b0;
      rf_we        = 1'b0;
      retire       = 1'b0;
    end
  end

  // Counter restarts on every state entry; only IF and MEM dwell.
  always_comb begin
    if (reset || (state_d != state_q))
      wait_d = 3'd0;
    else if ((state_q == S_IF) || (state_q == S_MEM))
      wait_d = wait_q + 3'd1;
    else
      wait_d = 3'd0;
  end

  assign state = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = reset ? 32'd0 : cycle_cnt_q + 32'd1;
    instret_cnt_d = reset ? 32'd0 : instret_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clk) begin
    cycle_cnt_q   <= cycle_cnt_d;
    instret_cnt_q <= instret_cnt_d;
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Purpose  : Scoreboard bench for mc_ctrl_fsm; per-cycle expected state and
//            strobes are queued per instruction and popped each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

  localparam int IMEM_LAT = 1;
  localparam int DMEM_LAT = 3;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_is_br, inst_is_jl, inst_is_ld, inst_is_st;
  logic        inst_gr_we, inst_legal, br_taken;
  logic [2:0]  state;
  logic        imem_req, ir_we, pc_we, pc_sel_br, dmem_req;
  logic        data_sram_we, rf_we, retire;
  logic [31:0] cycle_cnt, instret_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  // {state[2:0], imem, ir_we, pc_we, pc_sel_br, dmem, dsram_we, rf_we, retire}
  logic [10:0] sb[$];

  mc_ctrl_fsm #(.IMEM_LAT(IMEM_LAT), .DMEM_LAT(DMEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .inst_is_br(inst_is_br), .inst_is_jl(inst_is_jl),
    .inst_is_ld(inst_is_ld), .inst_is_st(inst_is_st),
    .inst_gr_we(inst_gr_we), .inst_legal(inst_legal), .br_taken(br_taken),
    .state(state), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel_br(pc_sel_br), .dmem_req(dmem_req), .data_sram_we(data_sram_we),
    .rf_we(rf_we), .retire(retire), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] vec(input logic [2:0] s, input logic im, iw, pw,
                                      ps, dm, dw, rw, rt);
    return {s, im, iw, pw, ps, dm, dw, rw, rt};
  endfunction

  function automatic logic [10:0] obs();
    return {state, imem_req, ir_we, pc_we, pc_sel_br, dmem_req, data_sram_we, rf_we, retire};
  endfunction

  // pc_sel_br only carries meaning while pc_we is expected.
  function automatic logic [10:0] cmp_mask(input logic [10:0] e);
    return e[5] ? 11'h7FF : 11'h7EF;
  endfunction

  task automatic set_dec(input logic br, jl, ld, st, gr, legal, taken);
    inst_is_br = br; inst_is_jl = jl; inst_is_ld = ld; inst_is_st = st;
    inst_gr_we = gr; inst_legal = legal; br_taken = taken;
  endtask

  // Reference sequencing model: expected per-cycle outputs for one instruction.
  task automatic push_instr(input logic br, jl, ld, st, gr, legal, taken);
    for (int i = 0; i <= IMEM_LAT; i++)
      sb.push_back(vec(S_IF, 1'b1, (i == IMEM_LAT), 0, 0, 0, 0, 0, 0));
    if (!legal)
      sb.push_back(vec(S_ID, 0, 0, 1, 0, 0, 0, 0, 1));
    else if (br)
      sb.push_back(vec(S_ID, 0, 0, 1, taken, 0, 0, 0, 1));
    else begin
      sb.push_back(vec(S_ID, 0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(vec(S_EXE, 0, 0, 0, 0, 0, 0, 0, 0));
      if (!jl && ld) begin
        for (int i = 0; i <= DMEM_LAT; i++)
          sb.push_back(vec(S_MEM, 0, 0, 0, 0, 1, 0, 0, 0));
        sb.push_back(vec(S_WB, 0, 0, 1, 0, 0, 0, gr, 1));
      end else if (!jl && st)
        sb.push_back(vec(S_MEM, 0, 0, 1, 0, 1, 1, 0, 1));
      else
        sb.push_back(vec(S_WB, 0, 0, 1, jl, 0, 0, gr, 1));
    end
  endtask

  task automatic test_reset();
    logic [10:0] got;
    reset = 1'b1;
    set_dec(0, 0, 0, 0, 1, 1, 0);
    repeat (3) begin
      @(negedge clk);
      got = obs();
      n_vec++;
      if (got !== vec(S_IF, 0, 0, 0, 0, 0, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL reset_state: got %b expected %b", got, vec(S_IF, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_alu();
    logic [10:0] got, exp;
    set_dec(0, 0, 0, 0, 1, 1, 0);
    push_instr(0, 0, 0, 0, 1, 1, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = obs(); n_vec++;
      if ((got & cmp_mask(exp)) !== (exp & cmp_mask(exp))) begin
        n_fail++; $display("FAIL alu_add: got %b expected %b", got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [10:0] got, exp;
    for (int t = 1; t >= 0; t--) begin
      set_dec(1, 0, 0, 0, 0, 1, t[0]);
      push_instr(1, 0, 0, 0, 0, 1, t[0]);
      while (sb.size() > 0) begin
        @(negedge clk);
        exp = sb.pop_front(); got = obs(); n_vec++;
        if ((got & cmp_mask(exp)) !== (exp & cmp_mask(exp))) begin
          n_fail++; $display("FAIL branch_taken%0d: got %b expected %b", t, got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_load();
    logic [10:0] got, exp;
    set_dec(0, 0, 1, 0, 1, 1, 0);
    push_instr(0, 0, 1, 0, 1, 1, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = obs(); n_vec++;
      if ((got & cmp_mask(exp)) !== (exp & cmp_mask(exp))) begin
        n_fail++; $display("FAIL load_dmem_lat: got %b expected %b", got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_bl();
    logic [10:0] got, exp;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        set_dec(0, 0, 0, 1, 0, 1, 0); push_instr(0, 0, 0, 1, 0, 1, 0);
      end else begin
        set_dec(0, 1, 0, 0, 1, 1, 0); push_instr(0, 1, 0, 0, 1, 1, 0);
      end
      while (sb.size() > 0) begin
        @(negedge clk);
        exp = sb.pop_front(); got = obs(); n_vec++;
        if ((got & cmp_mask(exp)) !== (exp & cmp_mask(exp))) begin
          n_fail++; $display("FAIL %s: got %b expected %b", (k == 0) ? "store" : "bl", got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_precedence();
    logic [10:0] got, exp;
    // illegal wins over everything; legal jl+ld goes down the jl path
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        set_dec(1, 0, 1, 0, 1, 0, 1); push_instr(1, 0, 1, 0, 1, 0, 1);
      end else begin
        set_dec(0, 1, 1, 1, 1, 1, 0); push_instr(0, 1, 1, 1, 1, 1, 0);
      end
      while (sb.size() > 0) begin
        @(negedge clk);
        exp = sb.pop_front(); got = obs(); n_vec++;
        if ((got & cmp_mask(exp)) !== (exp & cmp_mask(exp))) begin
          n_fail++; $display("FAIL %s: got %b expected %b", (k == 0) ? "illegal_nop" : "jl_over_ld", got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [10:0] got, exp;
    set_dec(0, 0, 1, 0, 1, 1, 0);
    push_instr(0, 0, 1, 0, 1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = sb.pop_front(); got = obs(); n_vec++;
      if ((got & cmp_mask(exp)) !== (exp & cmp_mask(exp))) begin
        n_fail++; $display("FAIL mid_reset_pre: got %b expected %b", got, exp);
      end
      @(posedge clk); #1;
    end
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    got = obs(); n_vec++;
    if (got[7:0] !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_strobes: got %b expected 00000000", got[7:0]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (state !== S_IF) begin
      n_fail++; $display("FAIL mid_reset_state: got %0d expected %0d", state, S_IF);
    end
    @(posedge clk); #1;
    // wait counter must have restarted: that IF cycle was the first of a fresh fetch
    set_dec(0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= IMEM_LAT; i++)
      sb.push_back(vec(S_IF, 1'b1, (i == IMEM_LAT), 0, 0, 0, 0, 0, 0));
    sb.push_back(vec(S_ID, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(vec(S_EXE, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(vec(S_WB, 0, 0, 1, 0, 0, 0, 1, 1));
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = obs(); n_vec++;
      if ((got & cmp_mask(exp)) !== (exp & cmp_mask(exp))) begin
        n_fail++; $display("FAIL mid_reset_restart: got %b expected %b", got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf_cnt();
    logic [10:0] got, exp;
    logic [31:0] exp_cyc, exp_ret;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    set_dec(0, 0, 0, 0, 1, 1, 0);
    for (int n = 0; n < 10; n++) begin
      push_instr(0, 0, 0, 0, 1, 1, 0);
      while (sb.size() > 0) begin
        @(negedge clk);
        exp = sb.pop_front(); got = obs(); n_vec++;
        if ((got & cmp_mask(exp)) !== (exp & cmp_mask(exp))) begin
          n_fail++; $display("FAIL perf_add%0d: got %b expected %b", n, got, exp);
        end
        @(posedge clk); #1;
      end
    end
`ifdef MC_PERF_CNT_EN
    // IF dwells IMEM_LAT+1 cycles, then ID, EXE, WB
    exp_cyc = 32'(10 * (IMEM_LAT + 4));
    exp_ret = 32'd10;
`else
    exp_cyc = 32'd0;
    exp_ret = 32'd0;
`endif
    @(negedge clk);
    n_vec++;
    if (instret_cnt !== exp_ret) begin
      n_fail++; $display("FAIL instret_cnt: got %0d expected %0d", instret_cnt, exp_ret);
    end
    n_vec++;
    if (cycle_cnt !== exp_cyc) begin
      n_fail++; $display("FAIL cycle_cnt: got %0d expected %0d", cycle_cnt, exp_cyc);
    end
`ifdef MC_PERF_CNT_EN
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_q;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (cycle_cnt !== 32'd0) begin
      n_fail++; $display("FAIL cycle_cnt_wrap: got %h expected 00000000", cycle_cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    set_dec(0, 0, 0, 0, 0, 1, 0);
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_store_bl();
    test_precedence();
    test_reset_mid_load();
    test_perf_cnt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
